// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one asynchronous-style data RAM port between two requesters:
//   port 0 is the I-cache line refill, port 1 the D-cache refill/write-through.
//   Round-robin arbitration, programmable wait states, line-burst reads with
//   per-word return, single word/byte writes. All outputs are registered.
//
//   Optional feature: define RAM_ARB_RANGE_CHECK_EN to reject requests whose
//   address span falls outside [START_ADDRESS, START_ADDRESS+MEM_BYTES-1].
//   Without it, err stays 0 and every request reaches the RAM.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req/we/bw [1:0]       per-port request, 1=write / 0=burst read, 1=word / 0=byte
//   addr/wdata [63:0]     per-port byte address / write data, port p at [32p+31:32p]
//   gnt/rvalid/done/err   per-port one-cycle pulses
//   rdata, rword          returned read word and its index within the line
//   busy                  1 whenever the arbiter is not idle
//   ram_*                 RAM address, data, active-low strobes, width select,
//                         and ram_drive to enable the external data-bus driver
module ram_port_arbiter #(
    parameter int unsigned LINE_WORDS    = 4,
    parameter int unsigned WAIT_CYCLES   = 1,
    parameter logic [31:0] START_ADDRESS = 32'h10010000,
    parameter int unsigned MEM_BYTES     = 128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    req,
    input  logic [1:0]                    we,
    input  logic [1:0]                    bw,
    input  logic [63:0]                   addr,
    input  logic [63:0]                   wdata,
    output logic [1:0]                    gnt,
    output logic [1:0]                    rvalid,
    output logic [31:0]                   rdata,
    output logic [$clog2(LINE_WORDS)-1:0] rword,
    output logic [1:0]                    done,
    output logic [1:0]                    err,
    output logic                          busy,
    output logic [31:0]                   ram_addr,
    output logic [31:0]                   ram_wdata,
    input  logic [31:0]                   ram_rdata,
    output logic                          ram_ce_n,
    output logic                          ram_oe_n,
    output logic                          ram_we_n,
    output logic                          ram_bw,
    output logic                          ram_drive
);

    localparam int unsigned WIDX = $clog2(LINE_WORDS);
    localparam logic [WIDX-1:0] WORD_LAST = WIDX'(LINE_WORDS - 1);
    localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_CYCLES);
    localparam logic [31:0] LINE_MASK  = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [32:0] RANGE_LO   = {1'b0, START_ADDRESS};
    localparam logic [32:0] RANGE_HI   = RANGE_LO + 33'(MEM_BYTES) - 33'd1;
`ifdef RAM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t            state, state_d;
    logic              rr, rr_d;
    logic              owner, owner_d;
    logic              wr_q, wr_d;
    logic              rej_q, rej_d;
    logic [3:0]        wait_cnt, wait_d;
    logic [WIDX-1:0]   word_cnt, word_d;

    logic [1:0]        gnt_d, rvalid_d, done_d, err_d;
    logic [31:0]       rdata_d;
    logic [WIDX-1:0]   rword_d;
    logic              busy_d;
    logic [31:0]       ram_addr_d, ram_wdata_d;
    logic              ram_ce_n_d, ram_oe_n_d, ram_we_n_d, ram_bw_d, ram_drive_d;

    // Winner selection and request decode for the IDLE cycle
    logic              win;
    logic              sel_we, sel_bw;
    logic [31:0]       sel_addr, sel_wdata, line_base;
    logic [32:0]       span_lo, span_hi;
    logic              reject;

    assign win       = (req == 2'b11) ? rr : req[1];
    assign sel_we    = win ? we[1] : we[0];
    assign sel_bw    = win ? bw[1] : bw[0];
    assign sel_addr  = win ? addr[63:32] : addr[31:0];
    assign sel_wdata = win ? wdata[63:32] : wdata[31:0];
    assign line_base = sel_addr & LINE_MASK;

    // Reads are checked over the whole aligned line, word writes over 4 bytes
    assign span_lo = {1'b0, (sel_we ? sel_addr : line_base)};
    assign span_hi = span_lo + (sel_we ? (sel_bw ? 33'd3 : 33'd0)
                                       : 33'(LINE_WORDS * 4 - 1));
    assign reject  = RANGE_CHECK && ((span_lo < RANGE_LO) || (span_hi > RANGE_HI));

    always_comb begin
        state_d     = state;
        rr_d        = rr;
        owner_d     = owner;
        wr_d        = wr_q;
        rej_d       = rej_q;
        wait_d      = wait_cnt;
        word_d      = word_cnt;
        gnt_d       = '0;
        rvalid_d    = '0;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = rdata;
        rword_d     = rword;
        busy_d      = busy;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        ram_ce_n_d  = ram_ce_n;
        ram_oe_n_d  = ram_oe_n;
        ram_we_n_d  = ram_we_n;
        ram_bw_d    = ram_bw;
        ram_drive_d = ram_drive;

        case (state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_d  = ST_ACCESS;
                    owner_d  = win;
                    wr_d     = sel_we;
                    rej_d    = reject;
                    wait_d   = '0;
                    word_d   = '0;
                    busy_d   = 1'b1;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    // A rejected request spends one strobe-free ACCESS cycle so
                    // that its done lands one cycle after gnt.
                    if (!reject) begin
                        ram_ce_n_d = 1'b0;
                        if (sel_we) begin
                            ram_we_n_d  = 1'b0;
                            ram_drive_d = 1'b1;
                            ram_bw_d    = sel_bw;
                            ram_addr_d  = sel_addr;
                            ram_wdata_d = sel_wdata;
                        end else begin
                            ram_oe_n_d = 1'b0;
                            ram_addr_d = line_base;
                        end
                    end
                end
            end

            ST_ACCESS: begin
                if (rej_q) begin
                    state_d = ST_DONE;
                    done_d  = owner ? 2'b10 : 2'b01;
                    err_d   = owner ? 2'b10 : 2'b01;
                end else if (wait_cnt == WAIT_LAST) begin
                    wait_d = '0;
                    if (wr_q) begin
                        state_d     = ST_DONE;
                        done_d      = owner ? 2'b10 : 2'b01;
                        ram_ce_n_d  = 1'b1;
                        ram_we_n_d  = 1'b1;
                        ram_drive_d = 1'b0;
                    end else begin
                        rdata_d    = ram_rdata;
                        rvalid_d   = owner ? 2'b10 : 2'b01;
                        rword_d    = word_cnt;
                        ram_addr_d = ram_addr + 32'd4;
                        word_d     = word_cnt + 1'b1;
                        // Last word: done is raised alongside its rvalid
                        if (word_cnt == WORD_LAST) begin
                            state_d    = ST_DONE;
                            done_d     = owner ? 2'b10 : 2'b01;
                            ram_ce_n_d = 1'b1;
                            ram_oe_n_d = 1'b1;
                        end
                    end
                end else begin
                    wait_d = wait_cnt + 4'd1;
                end
            end

            ST_DONE: begin
                state_d     = ST_IDLE;
                rr_d        = ~owner;
                rej_d       = 1'b0;
                busy_d      = 1'b0;
                rdata_d     = '0;
                rword_d     = '0;
                ram_addr_d  = '0;
                ram_wdata_d = '0;
                ram_bw_d    = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr       <= 1'b0;
            owner    <= 1'b0;
            wr_q     <= 1'b0;
            rej_q    <= 1'b0;
            wait_cnt <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_d;
            rr       <= rr_d;
            owner    <= owner_d;
            wr_q     <= wr_d;
            rej_q    <= rej_d;
            wait_cnt <= wait_d;
            word_cnt <= word_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            rvalid    <= '0;
            done      <= '0;
            err       <= '0;
            rdata     <= '0;
            rword     <= '0;
            busy      <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_ce_n  <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_bw    <= 1'b0;
            ram_drive <= 1'b0;
        end else begin
            gnt       <= gnt_d;
            rvalid    <= rvalid_d;
            done      <= done_d;
            err       <= err_d;
            rdata     <= rdata_d;
            rword     <= rword_d;
            busy      <= busy_d;
            ram_addr  <= ram_addr_d;
            ram_wdata <= ram_wdata_d;
            ram_ce_n  <= ram_ce_n_d;
            ram_oe_n  <= ram_oe_n_d;
            ram_we_n  <= ram_we_n_d;
            ram_bw    <= ram_bw_d;
            ram_drive <= ram_drive_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter (LINE_WORDS=4, WAIT_CYCLES=1, 128-byte RAM at
// 0x10010000). Expectations are queued when a request is driven and consumed
// by a negedge monitor when the DUT produces gnt, strobes, rvalid and done.
module tb_ram_port_arbiter;
    localparam int unsigned LW = 4;
    localparam int unsigned WC = 1;
`ifdef RAM_ARB_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we, bw;
    logic [63:0] addr, wdata;
    logic [1:0]  gnt, rvalid, done, err;
    logic [31:0] rdata;
    logic [1:0]  rword;
    logic        busy;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_ce_n, ram_oe_n, ram_we_n, ram_bw, ram_drive;

    ram_port_arbiter #(
        .LINE_WORDS   (LW),
        .WAIT_CYCLES  (WC),
        .START_ADDRESS(32'h10010000),
        .MEM_BYTES    (128)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .bw(bw),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .rword(rword), .done(done), .err(err), .busy(busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_bw(ram_bw), .ram_drive(ram_drive)
    );

    always #5 clk = ~clk;

    // RAM contents as a fixed function of the address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction
    assign ram_rdata = memf(ram_addr);

    function automatic logic [1:0] oh(input int unsigned p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int unsigned port; int unsigned cyc; } gnt_exp_t;
    typedef struct { int unsigned port; int unsigned word; logic [31:0] data; int unsigned cyc; } rv_exp_t;
    typedef struct { int unsigned port; bit err; int unsigned cyc; } done_exp_t;
    typedef struct { bit wr; bit bw; logic [31:0] addr; logic [31:0] wdata; int unsigned cyc; } st_exp_t;

    gnt_exp_t  gnt_q[$];
    rv_exp_t   rv_q[$];
    done_exp_t done_q[$];
    st_exp_t   st_q[$];

    gnt_exp_t  mg;
    rv_exp_t   mr;
    done_exp_t md;
    st_exp_t   ms;

    always @(negedge clk) begin
        if (!reset) begin
            if (gnt != 2'b00) begin
                check("gnt_onehot", $countones(gnt), 1);
                if (gnt_q.size() == 0) check("gnt_unexpected", gnt, 2'b00);
                else begin
                    mg = gnt_q.pop_front();
                    check("gnt_port", gnt, oh(mg.port));
                    check("gnt_cycle", cyc, mg.cyc);
                end
            end
            if (!ram_ce_n) begin
                if (st_q.size() == 0) check("strobe_unexpected", ram_ce_n, 1'b1);
                else begin
                    ms = st_q.pop_front();
                    check("strobe_cycle", cyc, ms.cyc);
                    check("ram_addr", ram_addr, ms.addr);
                    check("ram_ctl", {ram_oe_n, ram_we_n, ram_drive}, ms.wr ? 3'b101 : 3'b010);
                    if (ms.wr) begin
                        check("ram_bw", ram_bw, ms.bw);
                        check("ram_wdata", ram_wdata, ms.wdata);
                    end
                end
            end else begin
                check("ram_idle_ctl", {ram_oe_n, ram_we_n, ram_drive}, 3'b110);
            end
            if (rvalid != 2'b00) begin
                if (rv_q.size() == 0) check("rvalid_unexpected", rvalid, 2'b00);
                else begin
                    mr = rv_q.pop_front();
                    check("rvalid_port", rvalid, oh(mr.port));
                    check("rword", rword, mr.word);
                    check("rdata", rdata, mr.data);
                    check("rvalid_cycle", cyc, mr.cyc);
                end
            end
            if (done != 2'b00) begin
                if (done_q.size() == 0) check("done_unexpected", done, 2'b00);
                else begin
                    md = done_q.pop_front();
                    check("done_port", done, oh(md.port));
                    check("done_err", err, md.err ? oh(md.port) : 2'b00);
                    check("done_cycle", cyc, md.cyc);
                end
            end else if (err != 2'b00) begin
                check("err_without_done", err, 2'b00);
            end
        end
    end

    task automatic push_txn(input int unsigned p, input bit w, input bit b,
                            input logic [31:0] first, input logic [31:0] d,
                            input bit rej, input int unsigned issue);
        gnt_q.push_back('{p, issue});
        if (rej) begin
            done_q.push_back('{p, 1'b1, issue + 1});
        end else if (w) begin
            for (int unsigned i = 0; i <= WC; i++)
                st_q.push_back('{1'b1, b, first, d, issue + i});
            done_q.push_back('{p, 1'b0, issue + WC + 1});
        end else begin
            for (int unsigned k = 0; k < LW; k++) begin
                for (int unsigned i = 0; i <= WC; i++)
                    st_q.push_back('{1'b0, 1'b0, first + 4 * k, 32'h0, issue + k * (WC + 1) + i});
                rv_q.push_back('{p, k, memf(first + 4 * k), issue + (k + 1) * (WC + 1)});
            end
            done_q.push_back('{p, 1'b0, issue + LW * (WC + 1)});
        end
    endtask

    task automatic set_port(input int unsigned p, input bit w, input bit b,
                            input logic [31:0] a, input logic [31:0] d);
        we[p] = w;
        bw[p] = b;
        addr[p*32 +: 32]  = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy, 1'b0);
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    typedef struct {
        int unsigned port;
        bit          we;
        bit          bw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_addr;  // first ram_addr presented
        bit          oob;       // outside the 128-byte window
    } vec_t;

    vec_t vecs[8];
    int unsigned issue;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1'b0, 1'b0, 32'h10010014, 32'h0,        32'h10010010, 1'b0};
        vecs[1] = '{1, 1'b1, 1'b0, 32'h10010021, 32'hDEADBEEF, 32'h10010021, 1'b0};
        vecs[2] = '{1, 1'b0, 1'b0, 32'h1001007C, 32'h0,        32'h10010070, 1'b0};
        vecs[3] = '{0, 1'b1, 1'b1, 32'h1001007C, 32'h01234567, 32'h1001007C, 1'b0};
        vecs[4] = '{0, 1'b1, 1'b1, 32'h1001007D, 32'h89ABCDEF, 32'h1001007D, 1'b1};
        vecs[5] = '{1, 1'b0, 1'b0, 32'h10000000, 32'h0,        32'h10000000, 1'b1};
        vecs[6] = '{0, 1'b1, 1'b0, 32'h1001007F, 32'h000000A5, 32'h1001007F, 1'b0};
        vecs[7] = '{1, 1'b0, 1'b0, 32'h10010080, 32'h0,        32'h10010080, 1'b1};

        reset = 1'b1; req = '0; we = '0; bw = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_drive}, 4'b1110);
        check("rst_pulses", {gnt, rvalid, done, err}, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_data", {rdata, 30'b0, rword}, 64'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        reset = 1'b0;

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            wait_idle();
            set_port(vecs[i].port, vecs[i].we, vecs[i].bw, vecs[i].addr, vecs[i].wdata);
            req[vecs[i].port] = 1'b1;
            issue = cyc + 1;
            push_txn(vecs[i].port, vecs[i].we, vecs[i].bw, vecs[i].exp_addr,
                     vecs[i].wdata, vecs[i].oob && CHK, issue);
            @(negedge clk);
            req = '0;
        end

        // Both ports request continuously after reset: 0,1,0,1 with one idle cycle between
        wait_idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_port(0, 1'b1, 1'b1, 32'h10010040, 32'h11112222);
        set_port(1, 1'b1, 1'b1, 32'h10010044, 32'h33334444);
        @(negedge clk);
        req = 2'b11;
        issue = cyc + 1;
        for (int unsigned t = 0; t < 4; t++)
            push_txn(t % 2, 1'b1, 1'b1, (t % 2 == 0) ? 32'h10010040 : 32'h10010044,
                     (t % 2 == 0) ? 32'h11112222 : 32'h33334444, 1'b0, issue + 4 * t);
        for (int unsigned t = 0; t < 3; t++) begin
            wait_cyc(issue + 4 * t + 3);
            check("arb_idle_bubble", busy, 1'b0);
        end
        wait_cyc(issue + 12);
        req = '0;

        // Port 1 arrives mid-burst while port 0 keeps requesting: port 1 goes next
        wait_idle();
        set_port(0, 1'b0, 1'b0, 32'h10010034, 32'h0);
        req[0] = 1'b1;
        issue = cyc + 1;
        push_txn(0, 1'b0, 1'b0, 32'h10010030, 32'h0, 1'b0, issue);
        wait_cyc(issue + 3);
        set_port(1, 1'b1, 1'b1, 32'h10010008, 32'hCAFEF00D);
        req[1] = 1'b1;
        push_txn(1, 1'b1, 1'b1, 32'h10010008, 32'hCAFEF00D, 1'b0, issue + 10);
        push_txn(0, 1'b0, 1'b0, 32'h10010030, 32'h0, 1'b0, issue + 14);
        wait_cyc(issue + 9);
        check("late_idle_bubble", busy, 1'b0);
        wait_cyc(issue + 10);
        req[1] = 1'b0;
        wait_cyc(issue + 14);
        req[0] = 1'b0;

        // Reset after word 1 of a burst aborts it with no done
        wait_idle();
        set_port(0, 1'b0, 1'b0, 32'h10010058, 32'h0);
        req[0] = 1'b1;
        issue = cyc + 1;
        push_txn(0, 1'b0, 1'b0, 32'h10010050, 32'h0, 1'b0, issue);
        @(negedge clk);
        req = '0;
        wait_cyc(issue + 4);
        #1 reset = 1'b1;
        #1;
        check("abort_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_drive}, 4'b1110);
        check("abort_busy", busy, 1'b0);
        check("abort_pulses", {gnt, rvalid, done, err}, 8'h00);
        gnt_q.delete(); rv_q.delete(); done_q.delete(); st_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        req[0] = 1'b1;
        issue = cyc + 1;
        push_txn(0, 1'b0, 1'b0, 32'h10010050, 32'h0, 1'b0, issue);
        @(negedge clk);
        req = '0;

        wait_idle();
        repeat (3) @(negedge clk);
        check("sb_gnt_left", gnt_q.size(), 0);
        check("sb_rvalid_left", rv_q.size(), 0);
        check("sb_done_left", done_q.size(), 0);
        check("sb_strobe_left", st_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
